// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and Gray/binary helpers
package fifo_pkg;

    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEPTH          = 2 ** DEFAULT_ADDR_W;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Operates on 32 bits; zero-extended narrower codes convert correctly.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// rtl/sync_nff.sv - generic multi-flop synchroniser with synchronous active-high reset
module sync_nff #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/write_ptr_full_gen.sv
// rtl/write_ptr_full_gen.sv - write-domain pointer, full/almost-full, level and overflow generator
module write_ptr_full_gen
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = depth_of(ADDR_W) - 2
) (
    input  logic              wclk,
    input  logic              wreset,
    input  logic              wen,
    input  logic [ADDR_W:0]   rptr_gray,
    input  logic              ovf_clr,
    output logic              winc,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow
);

    localparam int              PW   = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_T = PW'(AF_THRESH);

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wgray_q, wgray_d;
    logic [ADDR_W:0] level_q, level_d;
    logic [ADDR_W:0] rq, rbin;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;

    sync_nff #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i   (wclk),
        .reset_i (wreset),
        .d_i     (rptr_gray),
        .q_o     (rq)
    );

    // Full compares against the synchronised read pointer, so it can only
    // release late; assertion tracks the write that fills with no delay.
    always_comb begin
        winc    = wen & ~full_q & ~wreset;
        wbin_d  = wbin_q + {{ADDR_W{1'b0}}, winc};
        wgray_d = PW'(bin2gray(32'(wbin_d)));
        rbin    = PW'(gray2bin(32'(rq)));
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
        af_d    = (level_d >= AF_T);
        ovf_d   = (wen & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (wreset) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr       = wbin_q[ADDR_W-1:0];
    assign wptr_gray   = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wlevel      = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_write_ptr_full_gen.sv
// tb/tb_write_ptr_full_gen.sv - self-checking bench for write_ptr_full_gen
module tb_write_ptr_full_gen;

    localparam int AW    = 3;
    localparam int SS    = 2;
    localparam int AF    = 6;
    localparam int DEPTH = 8;

    logic          wclk = 1'b0;
    logic          wreset = 1'b1;
    logic          wen = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   rptr_gray = '0;
    logic          winc;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wlevel;
    logic          overflow;

    write_ptr_full_gen #(
        .ADDR_W      (AW),
        .SYNC_STAGES (SS),
        .AF_THRESH   (AF)
    ) dut (
        .wclk        (wclk),
        .wreset      (wreset),
        .wen         (wen),
        .rptr_gray   (rptr_gray),
        .ovf_clr     (ovf_clr),
        .winc        (winc),
        .waddr       (waddr),
        .wptr_gray   (wptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain write/read counts, with the read count seen
    // through a delay queue as long as the synchroniser.
    int m_wcount = 0;
    int m_rcount = 0;
    int m_hist[$];
    int m_lvl = 0;
    bit m_full = 1'b0;
    bit m_af = 1'b0;
    bit m_ovf = 1'b0;

    typedef struct {
        bit rst;
        bit w;
        bit clr;
        bit cc;
        bit winc;
        int waddr;
        int gray;
        bit full;
        bit af;
        int lvl;
        bit ovf;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [AW:0] gray_of(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit w, input bit clr, input bit rinc,
                        input bit cc, output logic got_winc, output logic [AW-1:0] got_waddr);
        bit          exp_winc;
        int          rs;
        logic [AW:0] prev_gray;
        @(negedge wclk);
        wreset  = rst;
        wen     = w;
        ovf_clr = clr;
        if (rst) m_rcount = 0;
        else if (rinc && m_rcount < m_wcount) m_rcount++;
        rptr_gray = gray_of(m_rcount);
        #1;
        exp_winc  = w & ~m_full & ~rst;
        got_winc  = winc;
        got_waddr = waddr;
        if (cc) begin
            chk("winc", winc, exp_winc);
            chk("waddr", waddr, m_wcount % DEPTH);
        end
        prev_gray = wptr_gray;
        @(posedge wclk);
        if (rst) begin
            m_wcount = 0;
            m_full   = 0;
            m_af     = 0;
            m_lvl    = 0;
            m_ovf    = 0;
            m_hist.delete();
            for (int i = 0; i < SS; i++) m_hist.push_back(0);
        end else begin
            m_ovf    = (w & m_full) | (m_ovf & ~clr);
            m_wcount = m_wcount + int'(exp_winc);
            rs       = m_hist.pop_front();
            m_hist.push_back(m_rcount);
            m_lvl    = m_wcount - rs;
            m_full   = (m_lvl == DEPTH);
            m_af     = (m_lvl >= AF);
        end
        #1;
        chk("wptr_gray", wptr_gray, gray_of(m_wcount));
        chk("full", full, m_full);
        chk("almost_full", almost_full, m_af);
        chk("wlevel", wlevel, m_lvl);
        chk("overflow", overflow, m_ovf);
        if (!rst && cc) chk("gray_step", $countones(wptr_gray ^ prev_gray), int'(exp_winc));
    endtask

    logic          gw;
    logic [AW-1:0] ga;
    int            gray_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    initial begin
        tbl[0] = '{rst:1, w:1, clr:0, cc:0, winc:0, waddr:0, gray:0, full:0, af:0, lvl:0, ovf:0};
        tbl[1] = '{rst:1, w:1, clr:0, cc:1, winc:0, waddr:0, gray:0, full:0, af:0, lvl:0, ovf:0};
        for (int k = 1; k <= 8; k++) begin
            tbl[k+1] = '{rst:0, w:1, clr:0, cc:1, winc:1, waddr:k-1, gray:gray_seq[k-1],
                         full:(k == 8), af:(k >= 6), lvl:k, ovf:0};
        end
        tbl[10] = '{rst:0, w:1, clr:0, cc:1, winc:0, waddr:0, gray:12, full:1, af:1, lvl:8, ovf:1};
        tbl[11] = '{rst:0, w:1, clr:1, cc:1, winc:0, waddr:0, gray:12, full:1, af:1, lvl:8, ovf:1};
        tbl[12] = '{rst:0, w:0, clr:1, cc:1, winc:0, waddr:0, gray:12, full:1, af:1, lvl:8, ovf:0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].w, tbl[i].clr, 1'b0, tbl[i].cc, gw, ga);
            if (tbl[i].cc) begin
                chk("tbl_winc", gw, tbl[i].winc);
                chk("tbl_waddr", ga, tbl[i].waddr);
            end
            chk("tbl_gray", wptr_gray, tbl[i].gray);
            chk("tbl_full", full, tbl[i].full);
            chk("tbl_af", almost_full, tbl[i].af);
            chk("tbl_level", wlevel, tbl[i].lvl);
            chk("tbl_ovf", overflow, tbl[i].ovf);
        end

        // Drain latency: one read releases full on the third edge.
        step(0, 0, 0, 1, 1, gw, ga);
        chk("drain_full_e1", full, 1);
        step(0, 0, 0, 0, 1, gw, ga);
        chk("drain_full_e2", full, 1);
        step(0, 0, 0, 0, 1, gw, ga);
        chk("drain_full_e3", full, 0);
        chk("drain_level", wlevel, 7);

        // Reset mid-operation from level 5.
        step(0, 0, 0, 1, 1, gw, ga);
        step(0, 0, 0, 1, 1, gw, ga);
        repeat (3) step(0, 0, 0, 0, 1, gw, ga);
        chk("pre_reset_level", wlevel, 5);
        step(1, 1, 0, 0, 1, gw, ga);
        chk("rst_winc", gw, 0);
        chk("rst_gray", wptr_gray, 0);
        chk("rst_level", wlevel, 0);
        chk("rst_full", full, 0);
        chk("rst_waddr", waddr, 0);
        step(0, 1, 0, 0, 1, gw, ga);
        chk("resume_winc", gw, 1);
        chk("resume_waddr", ga, 0);
        chk("resume_waddr_next", waddr, 1);

        // Wrap with level kept at or below 4: full must never appear.
        for (int c = 0; c < 200; c++) begin
            step(0, ((m_wcount - m_rcount) < 4) && ($urandom_range(0, 3) != 0),
                 1'b0, $urandom_range(0, 1) == 1, 1, gw, ga);
            chk("no_false_full", full, 0);
        end

        // Unconstrained random traffic including full, overflow and resets.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4, 1, gw, ga);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
